// File: rtl/exc_pkg.sv
// Shared definitions for the writeback exception commit unit.
//  - Exception codes reported to the CSR file.
//  - Encodings of the instruction-side and data-side TLB exception buses.
//  - FSM state encoding and the BADV source selector.
package exc_pkg;

    localparam logic [5:0] ECODE_INT  = 6'h00;
    localparam logic [5:0] ECODE_PIL  = 6'h01;
    localparam logic [5:0] ECODE_PIS  = 6'h02;
    localparam logic [5:0] ECODE_PIF  = 6'h03;
    localparam logic [5:0] ECODE_PME  = 6'h04;
    localparam logic [5:0] ECODE_PPI  = 6'h07;
    localparam logic [5:0] ECODE_TLBR = 6'h3F;
    localparam logic [5:0] ECODE_ADEF = 6'h08;
    localparam logic [5:0] ECODE_ALE  = 6'h09;
    localparam logic [5:0] ECODE_SYS  = 6'h0B;
    localparam logic [5:0] ECODE_BRK  = 6'h0C;
    localparam logic [5:0] ECODE_INE  = 6'h0D;

    // Instruction-side TLB exception bus encoding
    localparam logic [1:0] ITLB_NONE = 2'd0;
    localparam logic [1:0] ITLB_TLBR = 2'd1;
    localparam logic [1:0] ITLB_PIF  = 2'd2;
    localparam logic [1:0] ITLB_PPI  = 2'd3;

    // Data-side TLB exception bus encoding
    localparam logic [2:0] DTLB_NONE = 3'd0;
    localparam logic [2:0] DTLB_TLBR = 3'd1;
    localparam logic [2:0] DTLB_PIL  = 3'd2;
    localparam logic [2:0] DTLB_PIS  = 3'd3;
    localparam logic [2:0] DTLB_PPI  = 3'd4;
    localparam logic [2:0] DTLB_PME  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        BADV_NONE  = 2'd0,
        BADV_PC    = 2'd1,
        BADV_VADDR = 2'd2
    } badv_sel_e;

endpackage

// File: rtl/exc_prio_enc.sv
// Combinational fixed-priority exception resolver.
// Configuration macro: EXC_TLB_EN (TLB sources resolved when defined).
// Ports:
//  has_int/ex_adef/ex_ale/is_syscall/ex_brk/ex_ine  in   individual exception sources
//  inst_tlb_ex [1:0], data_tlb_ex [2:0]             in   TLB exception codes
//  hit                                              out  some exception is pending
//  ecode [5:0]                                      out  winning exception code
//  badv_sel                                         out  source of the bad address
//  tlbr                                             out  winner is a TLB refill
module exc_prio_enc
    import exc_pkg::*;
(
    input  logic       has_int,
    input  logic       ex_adef,
    input  logic       ex_ale,
    input  logic       is_syscall,
    input  logic       ex_brk,
    input  logic       ex_ine,
    input  logic [1:0] inst_tlb_ex,
    input  logic [2:0] data_tlb_ex,
    output logic       hit,
    output logic [5:0] ecode,
    output badv_sel_e  badv_sel,
    output logic       tlbr
);

`ifndef EXC_TLB_EN
    // TLB buses are kept on the interface but play no part in resolution
    logic unused_tlb_s;
    assign unused_tlb_s = ^{inst_tlb_ex, data_tlb_ex};
`endif

    // Priority chain; the first matching source wins
    always_comb begin
        hit      = 1'b1;
        ecode    = 6'h00;
        badv_sel = BADV_NONE;
        tlbr     = 1'b0;
        if (has_int) begin
            ecode = ECODE_INT;
`ifdef EXC_TLB_EN
        end else if (data_tlb_ex == DTLB_PIL) begin
            ecode = ECODE_PIL;  badv_sel = BADV_VADDR;
        end else if (data_tlb_ex == DTLB_PIS) begin
            ecode = ECODE_PIS;  badv_sel = BADV_VADDR;
        end else if (inst_tlb_ex == ITLB_PIF) begin
            ecode = ECODE_PIF;  badv_sel = BADV_PC;
        end else if (data_tlb_ex == DTLB_PME) begin
            ecode = ECODE_PME;  badv_sel = BADV_VADDR;
        end else if (data_tlb_ex == DTLB_PPI) begin
            ecode = ECODE_PPI;  badv_sel = BADV_VADDR;
        end else if (inst_tlb_ex == ITLB_PPI) begin
            ecode = ECODE_PPI;  badv_sel = BADV_PC;
        end else if (data_tlb_ex == DTLB_TLBR) begin
            // data-side refill wins the address when both sides refill
            ecode = ECODE_TLBR; badv_sel = BADV_VADDR; tlbr = 1'b1;
        end else if (inst_tlb_ex == ITLB_TLBR) begin
            ecode = ECODE_TLBR; badv_sel = BADV_PC;    tlbr = 1'b1;
`endif
        end else if (ex_adef) begin
            ecode = ECODE_ADEF; badv_sel = BADV_PC;
        end else if (ex_ale) begin
            ecode = ECODE_ALE;  badv_sel = BADV_VADDR;
        end else if (is_syscall) begin
            ecode = ECODE_SYS;
        end else if (ex_brk) begin
            ecode = ECODE_BRK;
        end else if (ex_ine) begin
            ecode = ECODE_INE;
        end else begin
            hit = 1'b0;
        end
    end

endmodule

// File: rtl/wb_exc_commit.sv
// Writeback exception commit unit: latches the highest-priority WB exception
// (or ertn), holds the request to the CSR file until csr_ack, then asserts
// wb_cancel for FLUSH_CYC cycles. WB is stalled (wb_allowin=0) while busy.
// Configuration macro: EXC_TLB_EN (enables TLB exception sources and ex_tlbr).
// Ports:
//  clk, reset (sync, active-high)
//  wb_valid, wb_pc, wb_vaddr, wb_* exception flags, wb_inst_tlb_ex, wb_data_tlb_ex  in
//  wb_allowin, ex_req, ertn_req, ex_ecode, ex_esubcode, ex_era, ex_badv,
//  ex_badv_we, ex_tlbr, wb_cancel  out (all registered)
//  csr_ack  in
module wb_exc_commit
    import exc_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int FLUSH_CYC = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wb_valid,
    input  logic [DATA_W-1:0] wb_pc,
    input  logic [DATA_W-1:0] wb_vaddr,
    input  logic              wb_has_int,
    input  logic              wb_ex_adef,
    input  logic              wb_ex_ale,
    input  logic              wb_is_syscall,
    input  logic              wb_ex_brk,
    input  logic              wb_ex_ine,
    input  logic              wb_is_ertn,
    input  logic [1:0]        wb_inst_tlb_ex,
    input  logic [2:0]        wb_data_tlb_ex,
    output logic              wb_allowin,
    output logic              ex_req,
    output logic              ertn_req,
    output logic [5:0]        ex_ecode,
    output logic [7:0]        ex_esubcode,
    output logic [DATA_W-1:0] ex_era,
    output logic [DATA_W-1:0] ex_badv,
    output logic              ex_badv_we,
    output logic              ex_tlbr,
    input  logic              csr_ack,
    output logic              wb_cancel
);

    // Keep the counter at least one bit wide even when no flush window is used
    localparam int CNT_W = (FLUSH_CYC > 0) ? $clog2(FLUSH_CYC + 1) : 1;

    logic       hit_s;
    logic [5:0] ecode_s;
    badv_sel_e  badv_sel_s;
    logic       tlbr_s;

    exc_prio_enc u_prio (
        .has_int     (wb_has_int),
        .ex_adef     (wb_ex_adef),
        .ex_ale      (wb_ex_ale),
        .is_syscall  (wb_is_syscall),
        .ex_brk      (wb_ex_brk),
        .ex_ine      (wb_ex_ine),
        .inst_tlb_ex (wb_inst_tlb_ex),
        .data_tlb_ex (wb_data_tlb_ex),
        .hit         (hit_s),
        .ecode       (ecode_s),
        .badv_sel    (badv_sel_s),
        .tlbr        (tlbr_s)
    );

    state_e            state_q,   state_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;
    logic              allowin_q, allowin_d;
    logic              ex_req_q,  ex_req_d;
    logic              ertn_q,    ertn_d;
    logic              cancel_q,  cancel_d;
    logic [5:0]        ecode_q,   ecode_d;
    logic [DATA_W-1:0] era_q,     era_d;
    logic [DATA_W-1:0] badv_q,    badv_d;
    logic              badv_we_q, badv_we_d;
    logic              tlbr_q,    tlbr_d;

    // Next-state and next-output computation
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        allowin_d = allowin_q;
        ex_req_d  = ex_req_q;
        ertn_d    = ertn_q;
        cancel_d  = cancel_q;
        ecode_d   = ecode_q;
        era_d     = era_q;
        badv_d    = badv_q;
        badv_we_d = badv_we_q;
        tlbr_d    = tlbr_q;
        case (state_q)
            ST_IDLE: begin
                if (wb_valid && (hit_s || wb_is_ertn)) begin
                    state_d   = ST_REQ;
                    allowin_d = 1'b0;
                    if (hit_s) begin
                        // any exception outranks a simultaneous ertn
                        ex_req_d  = 1'b1;
                        ecode_d   = ecode_s;
                        era_d     = wb_pc;
                        badv_we_d = (badv_sel_s != BADV_NONE);
                        badv_d    = (badv_sel_s == BADV_PC)    ? wb_pc :
                                    (badv_sel_s == BADV_VADDR) ? wb_vaddr :
                                                                 {DATA_W{1'b0}};
`ifdef EXC_TLB_EN
                        tlbr_d    = tlbr_s;
`else
                        tlbr_d    = 1'b0;
`endif
                    end else begin
                        ertn_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (csr_ack) begin
                    ex_req_d = 1'b0;
                    ertn_d   = 1'b0;
                    if (FLUSH_CYC == 0) begin
                        state_d   = ST_IDLE;
                        allowin_d = 1'b1;
                        ecode_d   = 6'h00;
                        era_d     = {DATA_W{1'b0}};
                        badv_d    = {DATA_W{1'b0}};
                        badv_we_d = 1'b0;
                        tlbr_d    = 1'b0;
                    end else begin
                        state_d  = ST_FLUSH;
                        cnt_d    = CNT_W'(FLUSH_CYC);
                        cancel_d = 1'b1;
                    end
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_FLUSH: begin
                if (cnt_q <= CNT_W'(1)) begin
                    state_d   = ST_IDLE;
                    cnt_d     = {CNT_W{1'b0}};
                    cancel_d  = 1'b0;
                    allowin_d = 1'b1;
                    ecode_d   = 6'h00;
                    era_d     = {DATA_W{1'b0}};
                    badv_d    = {DATA_W{1'b0}};
                    badv_we_d = 1'b0;
                    tlbr_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d   = ST_IDLE;
                cnt_d     = {CNT_W{1'b0}};
                allowin_d = 1'b1;
                ex_req_d  = 1'b0;
                ertn_d    = 1'b0;
                cancel_d  = 1'b0;
                ecode_d   = 6'h00;
                era_d     = {DATA_W{1'b0}};
                badv_d    = {DATA_W{1'b0}};
                badv_we_d = 1'b0;
                tlbr_d    = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= {CNT_W{1'b0}};
            allowin_q <= 1'b1;
            ex_req_q  <= 1'b0;
            ertn_q    <= 1'b0;
            cancel_q  <= 1'b0;
            ecode_q   <= 6'h00;
            era_q     <= {DATA_W{1'b0}};
            badv_q    <= {DATA_W{1'b0}};
            badv_we_q <= 1'b0;
            tlbr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            allowin_q <= allowin_d;
            ex_req_q  <= ex_req_d;
            ertn_q    <= ertn_d;
            cancel_q  <= cancel_d;
            ecode_q   <= ecode_d;
            era_q     <= era_d;
            badv_q    <= badv_d;
            badv_we_q <= badv_we_d;
            tlbr_q    <= tlbr_d;
        end
    end

    assign wb_allowin  = allowin_q;
    assign ex_req      = ex_req_q;
    assign ertn_req    = ertn_q;
    assign ex_ecode    = ecode_q;
    assign ex_esubcode = 8'h00;
    assign ex_era      = era_q;
    assign ex_badv     = badv_q;
    assign ex_badv_we  = badv_we_q;
    assign ex_tlbr     = tlbr_q;
    assign wb_cancel   = cancel_q;

endmodule

// File: tb/tb_wb_exc_commit.sv
// Directed self-checking bench for wb_exc_commit (DATA_W=32, FLUSH_CYC=2).
module tb_wb_exc_commit;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_valid;
    logic [31:0] wb_pc, wb_vaddr;
    logic        wb_has_int, wb_ex_adef, wb_ex_ale, wb_is_syscall, wb_ex_brk, wb_ex_ine, wb_is_ertn;
    logic [1:0]  wb_inst_tlb_ex;
    logic [2:0]  wb_data_tlb_ex;
    logic        wb_allowin, ex_req, ertn_req, ex_badv_we, ex_tlbr, csr_ack, wb_cancel;
    logic [5:0]  ex_ecode;
    logic [7:0]  ex_esubcode;
    logic [31:0] ex_era, ex_badv;

    int checks = 0;
    int failures = 0;

    wb_exc_commit #(.DATA_W(32), .FLUSH_CYC(2)) dut (
        .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_vaddr(wb_vaddr),
        .wb_has_int(wb_has_int), .wb_ex_adef(wb_ex_adef), .wb_ex_ale(wb_ex_ale),
        .wb_is_syscall(wb_is_syscall), .wb_ex_brk(wb_ex_brk), .wb_ex_ine(wb_ex_ine),
        .wb_is_ertn(wb_is_ertn), .wb_inst_tlb_ex(wb_inst_tlb_ex), .wb_data_tlb_ex(wb_data_tlb_ex),
        .wb_allowin(wb_allowin), .ex_req(ex_req), .ertn_req(ertn_req), .ex_ecode(ex_ecode),
        .ex_esubcode(ex_esubcode), .ex_era(ex_era), .ex_badv(ex_badv), .ex_badv_we(ex_badv_we),
        .ex_tlbr(ex_tlbr), .csr_ack(csr_ack), .wb_cancel(wb_cancel)
    );

    always #5 clk = ~clk;

    // one clock edge, outputs sampled 1 time unit later
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        wb_valid = 1'b0; wb_has_int = 1'b0; wb_ex_adef = 1'b0; wb_ex_ale = 1'b0;
        wb_is_syscall = 1'b0; wb_ex_brk = 1'b0; wb_ex_ine = 1'b0; wb_is_ertn = 1'b0;
        wb_inst_tlb_ex = 2'd0; wb_data_tlb_ex = 3'd0;
    endtask

    // acknowledge the pending request and ride out the flush window
    task automatic ack_and_drain();
        csr_ack = 1'b1; step(); csr_ack = 1'b0;
        step(); step();
    endtask

    task automatic test_reset();
        reset = 1'b1; clear_inputs(); csr_ack = 1'b0; wb_pc = 32'h0; wb_vaddr = 32'h0;
        step(); step();
        reset = 1'b0;
        checks++; if (wb_allowin !== 1'b1) begin failures++; $display("FAIL reset_allowin got=%b exp=1", wb_allowin); end
        checks++; if ({ex_req, ertn_req, wb_cancel, ex_badv_we, ex_tlbr} !== 5'b0) begin failures++; $display("FAIL reset_flags got=%b exp=00000", {ex_req, ertn_req, wb_cancel, ex_badv_we, ex_tlbr}); end
        checks++; if (ex_ecode !== 6'h00 || ex_era !== 32'h0 || ex_esubcode !== 8'h00) begin failures++; $display("FAIL reset_payload ecode=%h era=%h sub=%h exp=0", ex_ecode, ex_era, ex_esubcode); end
    endtask

    task automatic test_syscall_flush();
        wb_valid = 1'b1; wb_is_syscall = 1'b1; wb_pc = 32'h1C000010; wb_vaddr = 32'h12345678;
        step(); clear_inputs();
        checks++; if (ex_req !== 1'b1 || ertn_req !== 1'b0) begin failures++; $display("FAIL sys_req got ex=%b ertn=%b exp=1/0", ex_req, ertn_req); end
        checks++; if (ex_ecode !== 6'h0B) begin failures++; $display("FAIL sys_ecode got=%h exp=0b", ex_ecode); end
        checks++; if (ex_era !== 32'h1C000010 || ex_badv_we !== 1'b0) begin failures++; $display("FAIL sys_era got=%h we=%b exp=1c000010/0", ex_era, ex_badv_we); end
        checks++; if (wb_allowin !== 1'b0) begin failures++; $display("FAIL sys_allowin got=%b exp=0", wb_allowin); end
        step(); step(); step();
        checks++; if (ex_req !== 1'b1 || ex_ecode !== 6'h0B || wb_cancel !== 1'b0) begin failures++; $display("FAIL sys_hold req=%b ecode=%h cancel=%b exp=1/0b/0", ex_req, ex_ecode, wb_cancel); end
        csr_ack = 1'b1; step(); csr_ack = 1'b0;
        // a new syscall arriving during the flush window must be ignored
        wb_valid = 1'b1; wb_is_syscall = 1'b1; wb_pc = 32'h1C000020;
        checks++; if (ex_req !== 1'b0 || wb_cancel !== 1'b1 || wb_allowin !== 1'b0) begin failures++; $display("FAIL flush1 req=%b cancel=%b allowin=%b exp=0/1/0", ex_req, wb_cancel, wb_allowin); end
        step();
        checks++; if (wb_cancel !== 1'b1 || wb_allowin !== 1'b0) begin failures++; $display("FAIL flush2 cancel=%b allowin=%b exp=1/0", wb_cancel, wb_allowin); end
        step(); clear_inputs();
        checks++; if (wb_cancel !== 1'b0 || wb_allowin !== 1'b1 || ex_req !== 1'b0) begin failures++; $display("FAIL flush_end cancel=%b allowin=%b req=%b exp=0/1/0", wb_cancel, wb_allowin, ex_req); end
        checks++; if (ex_ecode !== 6'h00 || ex_era !== 32'h0) begin failures++; $display("FAIL idle_clear ecode=%h era=%h exp=0/0", ex_ecode, ex_era); end
        step();
        checks++; if (ex_req !== 1'b0 || wb_allowin !== 1'b1) begin failures++; $display("FAIL flush_sys_ignored req=%b allowin=%b exp=0/1", ex_req, wb_allowin); end
    endtask

    task automatic test_ale_priority();
        wb_valid = 1'b1; wb_ex_ale = 1'b1; wb_is_syscall = 1'b1; wb_pc = 32'h1C000100; wb_vaddr = 32'h00000803;
        step(); clear_inputs();
        checks++; if (ex_ecode !== 6'h09 || ex_badv !== 32'h00000803 || ex_badv_we !== 1'b1) begin failures++; $display("FAIL ale_sys ecode=%h badv=%h we=%b exp=09/00000803/1", ex_ecode, ex_badv, ex_badv_we); end
        ack_and_drain();
        wb_valid = 1'b1; wb_ex_adef = 1'b1; wb_ex_ale = 1'b1; wb_pc = 32'h1C000202; wb_vaddr = 32'h0000BEEF;
        step(); clear_inputs();
        checks++; if (ex_ecode !== 6'h08 || ex_badv !== 32'h1C000202 || ex_badv_we !== 1'b1) begin failures++; $display("FAIL adef ecode=%h badv=%h we=%b exp=08/1c000202/1", ex_ecode, ex_badv, ex_badv_we); end
        ack_and_drain();
        wb_valid = 1'b1; wb_has_int = 1'b1; wb_ex_adef = 1'b1; wb_ex_ine = 1'b1; wb_pc = 32'h1C000300;
        step(); clear_inputs();
        checks++; if (ex_ecode !== 6'h00 || ex_badv_we !== 1'b0 || ex_req !== 1'b1 || ex_era !== 32'h1C000300) begin failures++; $display("FAIL int ecode=%h we=%b req=%b era=%h exp=00/0/1/1c000300", ex_ecode, ex_badv_we, ex_req, ex_era); end
        ack_and_drain();
        wb_valid = 1'b1; wb_ex_brk = 1'b1; wb_ex_ine = 1'b1;
        step(); clear_inputs();
        checks++; if (ex_ecode !== 6'h0C) begin failures++; $display("FAIL brk ecode=%h exp=0c", ex_ecode); end
        ack_and_drain();
    endtask

    task automatic test_ertn();
        wb_valid = 1'b1; wb_is_ertn = 1'b1;
        step(); clear_inputs();
        checks++; if (ertn_req !== 1'b1 || ex_req !== 1'b0 || ex_badv_we !== 1'b0) begin failures++; $display("FAIL ertn_alone ertn=%b ex=%b we=%b exp=1/0/0", ertn_req, ex_req, ex_badv_we); end
        ack_and_drain();
        wb_valid = 1'b1; wb_is_ertn = 1'b1; wb_ex_ine = 1'b1;
        step(); clear_inputs();
        checks++; if (ex_req !== 1'b1 || ertn_req !== 1'b0 || ex_ecode !== 6'h0D) begin failures++; $display("FAIL ertn_ine ex=%b ertn=%b ecode=%h exp=1/0/0d", ex_req, ertn_req, ex_ecode); end
        ack_and_drain();
        wb_valid = 1'b0; wb_is_syscall = 1'b1;
        step(); clear_inputs();
        checks++; if (ex_req !== 1'b0 || wb_allowin !== 1'b1) begin failures++; $display("FAIL valid_low req=%b allowin=%b exp=0/1", ex_req, wb_allowin); end
    endtask

    task automatic test_tlb();
`ifdef EXC_TLB_EN
        wb_valid = 1'b1; wb_data_tlb_ex = 3'd1; wb_inst_tlb_ex = 2'd2; wb_pc = 32'h1C000400; wb_vaddr = 32'h00A00000;
        step(); clear_inputs();
        checks++; if (ex_ecode !== 6'h03 || ex_tlbr !== 1'b0 || ex_badv !== 32'h1C000400) begin failures++; $display("FAIL tlb_pif ecode=%h tlbr=%b badv=%h exp=03/0/1c000400", ex_ecode, ex_tlbr, ex_badv); end
        ack_and_drain();
        wb_valid = 1'b1; wb_data_tlb_ex = 3'd1; wb_inst_tlb_ex = 2'd1;
        step(); clear_inputs();
        checks++; if (ex_ecode !== 6'h3F || ex_tlbr !== 1'b1 || ex_badv !== 32'h00A00000) begin failures++; $display("FAIL tlb_refill ecode=%h tlbr=%b badv=%h exp=3f/1/00a00000", ex_ecode, ex_tlbr, ex_badv); end
        ack_and_drain();
`else
        wb_valid = 1'b1; wb_data_tlb_ex = 3'd1; wb_inst_tlb_ex = 2'd2;
        step(); clear_inputs();
        checks++; if (ex_req !== 1'b0 || wb_allowin !== 1'b1) begin failures++; $display("FAIL tlb_ignored req=%b allowin=%b exp=0/1", ex_req, wb_allowin); end
        wb_valid = 1'b1; wb_data_tlb_ex = 3'd2; wb_ex_brk = 1'b1;
        step(); clear_inputs();
        checks++; if (ex_ecode !== 6'h0C || ex_tlbr !== 1'b0) begin failures++; $display("FAIL tlb_off_brk ecode=%h tlbr=%b exp=0c/0", ex_ecode, ex_tlbr); end
        ack_and_drain();
`endif
    endtask

    task automatic test_reset_mid();
        wb_valid = 1'b1; wb_is_syscall = 1'b1;
        step(); clear_inputs();
        reset = 1'b1; step(); reset = 1'b0;
        checks++; if (ex_req !== 1'b0 || wb_allowin !== 1'b1 || wb_cancel !== 1'b0) begin failures++; $display("FAIL reset_in_req req=%b allowin=%b cancel=%b exp=0/1/0", ex_req, wb_allowin, wb_cancel); end
        wb_valid = 1'b1; wb_ex_ale = 1'b1; wb_vaddr = 32'h00000011;
        step(); clear_inputs();
        csr_ack = 1'b1; step(); csr_ack = 1'b0;
        reset = 1'b1; step(); reset = 1'b0;
        checks++; if (wb_cancel !== 1'b0 || wb_allowin !== 1'b1 || ex_badv_we !== 1'b0) begin failures++; $display("FAIL reset_in_flush cancel=%b allowin=%b we=%b exp=0/1/0", wb_cancel, wb_allowin, ex_badv_we); end
        // back-to-back: a fresh exception right after reset is accepted
        wb_valid = 1'b1; wb_ex_ine = 1'b1;
        step(); clear_inputs();
        checks++; if (ex_req !== 1'b1 || ex_ecode !== 6'h0D) begin failures++; $display("FAIL after_reset req=%b ecode=%h exp=1/0d", ex_req, ex_ecode); end
    endtask

    initial begin
        test_reset();
        test_syscall_flush();
        test_ale_priority();
        test_ertn();
        test_tlb();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
